// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter sharing one single-ported slave between the
// CPU data master (m0) and the UDM debug master (m1). One transaction per cycle.
// Grant and ack are combinational. Read responses are routed back to the
// issuing master through a fixed-latency tag pipeline.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   m0_* / m1_*                  master request side (req/we/addr/wdata/be in,
//                                ack/resp/rdata out)
//   s_req/s_we/s_addr/s_wdata/s_be  slave request side
//   s_rdata                      slave read data, valid RD_LATENCY cycles after
//                                an accepted read
module bus_arbiter_2m #(
  parameter int unsigned RD_LATENCY    = 1,
  parameter bit          M0_PRIO_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic        m0_resp,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic        m1_resp,
  output logic [31:0] m1_rdata,

  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_be,
  input  logic [31:0] s_rdata
);

  localparam int unsigned DW = 32;

  // Index of the master granted most recently (0 = m0, 1 = m1).
  logic last_grant;

  logic gnt_vld;
  logic gnt_id;

  // Tag pipeline: one {valid, master_id} entry per cycle of read latency.
  logic [RD_LATENCY-1:0] tag_vld;
  logic [RD_LATENCY-1:0] tag_id;

  logic rsp_vld;
  logic rsp_id;

  // Round-robin grant; contention goes to the master that did not win last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!rst_i) begin
      if (m0_req && m1_req) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant;
      end else if (m0_req) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (m1_req) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  // Slave mux; with no grant the payload follows m0 but req/we are held low.
  always_comb begin
    s_req   = gnt_vld;
    s_we    = 1'b0;
    s_addr  = m0_addr;
    s_wdata = m0_wdata;
    s_be    = m0_be;
    if (gnt_id) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_be    = m1_be;
    end
    if (gnt_vld) begin
      s_we = gnt_id ? m1_we : m0_we;
    end
  end

  // Zero-latency acceptance for whichever master holds the grant.
  always_comb begin
    m0_ack = gnt_vld & ~gnt_id;
    m1_ack = gnt_vld &  gnt_id;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= M0_PRIO_RESET;
    end else if (gnt_vld) begin
      last_grant <= gnt_id;
    end
  end

  // Free-running shift; writes enter as invalid so they never produce a resp.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= gnt_vld & ~s_we;
      tag_id[0]  <= gnt_id;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Last stage lines up with s_rdata; steer it to the issuing master only.
  always_comb begin
    rsp_vld  = tag_vld[RD_LATENCY-1] & ~rst_i;
    rsp_id   = tag_id[RD_LATENCY-1];
    m0_resp  = rsp_vld & ~rsp_id;
    m1_resp  = rsp_vld &  rsp_id;
    m0_rdata = m0_resp ? s_rdata : DW'(0);
    m1_rdata = m1_resp ? s_rdata : DW'(0);
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed bench for bus_arbiter_2m: a latency-1 and a latency-3 instance share
// master-side stimulus; each has its own slave read data and observed outputs.
module tb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_be = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_be = '0;

  logic [31:0] s_rdata1 = '0, s_rdata3 = '0;

  logic        m0_ack1, m0_resp1, m1_ack1, m1_resp1, s_req1, s_we1;
  logic [31:0] m0_rdata1, m1_rdata1, s_addr1, s_wdata1;
  logic [3:0]  s_be1;
  logic        m0_ack3, m0_resp3, m1_ack3, m1_resp3, s_req3, s_we3;
  logic [31:0] m0_rdata3, m1_rdata3, s_addr3, s_wdata3;
  logic [3:0]  s_be3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bus_arbiter_2m #(.RD_LATENCY(1), .M0_PRIO_RESET(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_ack(m0_ack1), .m0_resp(m0_resp1), .m0_rdata(m0_rdata1),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_ack(m1_ack1), .m1_resp(m1_resp1), .m1_rdata(m1_rdata1),
    .s_req(s_req1), .s_we(s_we1), .s_addr(s_addr1), .s_wdata(s_wdata1),
    .s_be(s_be1), .s_rdata(s_rdata1)
  );

  bus_arbiter_2m #(.RD_LATENCY(3), .M0_PRIO_RESET(1'b1)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_ack(m0_ack3), .m0_resp(m0_resp3), .m0_rdata(m0_rdata3),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_ack(m1_ack3), .m1_resp(m1_resp3), .m1_rdata(m1_rdata3),
    .s_req(s_req3), .s_we(s_we3), .s_addr(s_addr3), .s_wdata(s_wdata3),
    .s_be(s_be3), .s_rdata(s_rdata3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    s_rdata1 = '0; s_rdata3 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
    nxt();
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) nxt();
  endtask

  initial begin
    // Reset: requests present but everything gated off
    rst = 1'b1;
    nxt();
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b1;
    mid();
    chk("rst_s_req", 32'(s_req1), 32'd0);
    chk("rst_s_we", 32'(s_we1), 32'd0);
    chk("rst_m0_ack", 32'(m0_ack1), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack1), 32'd0);
    chk("rst_resp", 32'({m0_resp1, m1_resp1}), 32'd0);
    chk("rst_rdata", m0_rdata1 | m1_rdata1, 32'd0);
    do_reset();

    // Lone m0 read, latency 1
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    mid();
    chk("t1_m0_ack", 32'(m0_ack1), 32'd1);
    chk("t1_m1_ack", 32'(m1_ack1), 32'd0);
    chk("t1_s_req", 32'(s_req1), 32'd1);
    chk("t1_s_we", 32'(s_we1), 32'd0);
    chk("t1_s_addr", s_addr1, 32'h0000_0010);
    nxt();
    m0_req = 1'b0; s_rdata1 = 32'hDEAD_BEEF;
    mid();
    chk("t1_m0_resp", 32'(m0_resp1), 32'd1);
    chk("t1_m0_rdata", m0_rdata1, 32'hDEAD_BEEF);
    chk("t1_m1_resp", 32'(m1_resp1), 32'd0);
    chk("t1_m1_rdata", m1_rdata1, 32'd0);
    nxt();
    s_rdata1 = 32'hDEAD_BEEF;
    mid();
    chk("t1_m0_resp_end", 32'(m0_resp1), 32'd0);
    chk("t1_m0_rdata_end", m0_rdata1, 32'd0);

    // Both masters writing continuously: grants alternate starting with m0
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_00A0; m0_wdata = 32'h1111_0000; m0_be = 4'h3;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_00B0; m1_wdata = 32'h2222_0000; m1_be = 4'hC;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("t2_s_req", 32'(s_req1), 32'd1);
      chk("t2_s_we", 32'(s_we1), 32'd1);
      chk("t2_m0_ack", 32'(m0_ack1), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_m1_ack", 32'(m1_ack1), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("t2_s_addr", s_addr1, (k % 2 == 0) ? 32'h0000_00A0 : 32'h8000_00B0);
      chk("t2_s_wdata", s_wdata1, (k % 2 == 0) ? 32'h1111_0000 : 32'h2222_0000);
      chk("t2_s_be", 32'(s_be1), (k % 2 == 0) ? 32'h3 : 32'hC);
      chk("t2_resp", 32'({m0_resp1, m1_resp1}), 32'd0);
      nxt();
    end
    mid();
    chk("t2_resp_tail", 32'({m0_resp1, m1_resp1}), 32'd0);
    idle(4);

    // Interleaved reads; last grant was m1 so m0 wins the contention
    m0_req = 1'b1; m0_addr = 32'h0000_0100;
    m1_req = 1'b1; m1_addr = 32'h8000_0004;
    mid();
    chk("t3_c0_m0_ack", 32'(m0_ack1), 32'd1);
    chk("t3_c0_m1_ack", 32'(m1_ack1), 32'd0);
    chk("t3_c0_s_addr", s_addr1, 32'h0000_0100);
    nxt();
    m0_req = 1'b0; s_rdata1 = 32'h0000_0011;
    mid();
    chk("t3_c1_m1_ack", 32'(m1_ack1), 32'd1);
    chk("t3_c1_s_addr", s_addr1, 32'h8000_0004);
    chk("t3_c1_m0_resp", 32'(m0_resp1), 32'd1);
    chk("t3_c1_m0_rdata", m0_rdata1, 32'h0000_0011);
    chk("t3_c1_m1_resp", 32'(m1_resp1), 32'd0);
    nxt();
    m1_req = 1'b0; s_rdata1 = 32'h0000_0022;
    mid();
    chk("t3_c2_s_req", 32'(s_req1), 32'd0);
    chk("t3_c2_m1_resp", 32'(m1_resp1), 32'd1);
    chk("t3_c2_m1_rdata", m1_rdata1, 32'h0000_0022);
    chk("t3_c2_m0_resp", 32'(m0_resp1), 32'd0);
    chk("t3_c2_m0_rdata", m0_rdata1, 32'd0);
    idle(6);

    // Latency 3: m1 issues three back-to-back reads
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200 + 32'(4 * k);
        m1_wdata = 32'h5A5A_0000; m1_be = 4'hF;
      end else begin
        m1_req = 1'b0;
      end
      s_rdata3 = (k >= 3) ? 32'h0000_00A0 + 32'(k - 2) : 32'hFFFF_FFFF;
      mid();
      if (k < 3) begin
        chk("t4_m1_ack", 32'(m1_ack3), 32'd1);
        chk("t4_m0_ack", 32'(m0_ack3), 32'd0);
        chk("t4_s_addr", s_addr3, 32'h0000_0200 + 32'(4 * k));
        chk("t4_s_we", 32'(s_we3), 32'd0);
        chk("t4_s_wdata", s_wdata3, 32'h5A5A_0000);
        chk("t4_s_be", 32'(s_be3), 32'hF);
        chk("t4_m1_resp_early", 32'(m1_resp3), 32'd0);
      end else begin
        chk("t4_s_req", 32'(s_req3), 32'd0);
        chk("t4_m1_resp", 32'(m1_resp3), 32'd1);
        chk("t4_m1_rdata", m1_rdata3, 32'h0000_00A0 + 32'(k - 2));
      end
      chk("t4_m0_resp", 32'(m0_resp3), 32'd0);
      chk("t4_m0_rdata", m0_rdata3, 32'd0);
      nxt();
    end
    s_rdata3 = 32'hFFFF_FFFF;
    mid();
    chk("t4_m1_resp_end", 32'(m1_resp3), 32'd0);
    idle(4);

    // Async reset drops an outstanding read and restores m0 priority
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0040;
    mid();
    chk("t5_m0_ack", 32'(m0_ack1), 32'd1);
    nxt();
    m0_req = 1'b0; s_rdata1 = 32'hCAFE_F00D;
    #2 rst = 1'b1;
    mid();
    chk("t5_m0_resp_dropped", 32'(m0_resp1), 32'd0);
    chk("t5_m0_rdata_dropped", m0_rdata1, 32'd0);
    nxt();
    m0_req = 1'b1; m1_req = 1'b1;
    #1;
    chk("t5_rst_s_req", 32'(s_req1), 32'd0);
    #1 rst = 1'b0;
    mid();
    chk("t5_post_m0_ack", 32'(m0_ack1), 32'd1);
    chk("t5_post_m1_ack", 32'(m1_ack1), 32'd0);
    chk("t5_post_m0_resp", 32'(m0_resp1), 32'd0);
    nxt();
    m0_req = 1'b0;
    mid();
    chk("t5_post_m1_ack2", 32'(m1_ack1), 32'd1);
    chk("t5_post_m0_resp2", 32'(m0_resp1), 32'd1);
    idle(5);

    // Idle bus: stray we/address must not reach the slave as a request
    m0_we = 1'b1; m0_addr = 32'h8000_0000;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk("t6_s_req", 32'(s_req1), 32'd0);
      chk("t6_s_we", 32'(s_we1), 32'd0);
      chk("t6_ack", 32'({m0_ack1, m1_ack1}), 32'd0);
      chk("t6_resp", 32'({m0_resp1, m1_resp1}), 32'd0);
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master round-robin arbiter that shares one single-ported memory/IO slave port (RAM + LED/SW IO window) between the CPU data master (m0) and the UDM debug bus master (m1).
- Accepts at most one transaction per cycle.
- Tracks outstanding reads through a fixed-latency tag pipeline and routes each read response back to the master that issued it.
- Sits between the core/UDM and the bus unit's data-side port.

Parameters:
- RD_LATENCY, 1, slave read latency in cycles (1..4); rdata is valid exactly RD_LATENCY cycles after an accepted read.
- M0_PRIO_RESET, 1, if 1 then m0 wins the first contention after reset; if 0 then m1 wins.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- m0_req  in  1  m0 request, held until m0_ack
- m0_we  in  1  m0 write enable
- m0_addr  in  32  m0 byte address
- m0_wdata  in  32  m0 write data
- m0_be  in  4  m0 byte enables
- m0_ack  out  1  m0 request accepted this cycle
- m0_resp  out  1  m0 read data valid
- m0_rdata  out  32  m0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_ack, m1_resp, m1_rdata  same as m0, for m1
- s_req  out  1  slave request
- s_we  out  1  slave write enable
- s_addr  out  32  slave address
- s_wdata  out  32  slave write data
- s_be  out  4  slave byte enables
- s_rdata  in  32  slave read data, valid RD_LATENCY cycles after an accepted read

Behaviour:
- Reset: asynchronous, active-high on rst_i; all registers clear immediately.
  - last_grant is set to 1 if M0_PRIO_RESET, else 0.
  - Tag pipeline valid bits are cleared.
  - While rst_i is high: s_req=0, m0_ack=m1_ack=0, m0_resp=m1_resp=0, m*_rdata=0.
- Grant (combinational, same cycle as the request):
  - Only one master requesting: that master is granted.
  - Both requesting: grant goes to the master not equal to last_grant.
  - No master requesting: no grant; s_req=0 and s_we=0. s_addr, s_wdata and s_be follow m0 and are don't-care.
- Slave drive: s_req=1 and s_we/addr/wdata/be are muxed from the granted master.
- Acknowledge: m*_ack=1 for the granted master in the grant cycle, so acceptance has zero extra latency.
  - A master that sees ack may present a new request in the next cycle.
  - A non-granted master keeps req asserted and stalls.
  - Zero-wait for back-to-back single-master traffic: a continuously requesting lone master is acked every cycle.
- last_grant update: registered to the granted master's index on every grant cycle; holds otherwise.
- Fairness: with both masters requesting continuously, grants alternate every cycle and neither waits more than 1 cycle.
- Read tracking:
  - Tag pipeline is RD_LATENCY stages of {valid, master_id}.
  - Stage 0 is loaded with {granted && !s_we, grant_id}. Writes load valid=0.
  - The pipeline shifts every cycle unconditionally, with no backpressure.
  - At the last stage, if valid: m<id>_resp=1 and m<id>_rdata=s_rdata. The other master sees resp=0 and rdata=0.
  - Writes produce no resp.
- Simultaneous events: a response delivery for one master and a new grant to the other in the same cycle are independent and both occur.
- Overlap: a master may have up to RD_LATENCY reads outstanding. Responses return in issue order.
- Reset mid-operation: outstanding reads are dropped and no resp is ever emitted for them. Masters must re-issue.
- Masters must not change we/addr/wdata/be while req=1 and ack=0. The arbiter does not check this.
- Arithmetic: none beyond muxing. Addresses pass through unmodified at full 32 bits, including the 0x8000_0000+ IO region.

Test Plan:
- Reset then m0 read of addr 0x0000_0010 alone, with the slave returning 0xDEADBEEF after RD_LATENCY=1 → m0_ack in cycle 0; m0_resp=1 and m0_rdata=0xDEADBEEF in cycle 1; m1_resp stays 0.
- Both masters write every cycle for 6 cycles, with M0_PRIO_RESET=1 → s_req=1 each cycle; acks alternate m0,m1,m0,m1,m0,m1; s_addr matches the granted master; no resp pulses.
- Interleaved reads: m0 reads 0x100 and m1 reads 0x8000_0004 in the same cycle (slave echoes 0x11 then 0x22) → cycle 0 grants m0, cycle 1 grants m1; m0_resp with 0x11 in cycle 1; m1_resp with 0x22 in cycle 2.
- RD_LATENCY=3, m1 issues 3 back-to-back reads → 3 acks on consecutive cycles; m1_resp in cycles 3,4,5 with data in issue order.
- Assert rst_i asynchronously (mid-cycle) one cycle after an accepted m0 read → no m0_resp after reset; first contention afterwards grants m0.
- Idle bus with no req → s_req=0 and s_we=0 for 10 cycles; no acks or resps.
